// File: rtl/des_hash_pkg.sv
// Shared definitions for the S-box hash engine: DES S5 lookup, byte
// compression, state encoding and default initial state.
package des_hash_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ABSORB = 2'd1,
    ST_FINAL  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [31:0] DEFAULT_IV = 32'h30FD17B4;

  // 8-bit byte folded to the 6-bit S-box input
  function automatic logic [5:0] c6(input logic [7:0] b);
    return {b[3] ^ b[2], b[1], b[0], b[7], b[6], b[5] ^ b[4]};
  endfunction

  // Rows packed with column 0 in the top nibble
  function automatic logic [3:0] sbox5(input logic [5:0] in);
    logic [63:0] row_bits;
    logic [3:0]  idx;
    unique case ({in[5], in[0]})
      2'd0:    row_bits = 64'h2C417AB6853FD0E9;
      2'd1:    row_bits = 64'hEB2C47D150FA3986;
      2'd2:    row_bits = 64'h421BAD78F9C5630E;
      default: row_bits = 64'hB8C71E2D6F09A453;
    endcase
    idx = 4'd15 - in[4:1];
    return row_bits[{idx, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] rotl4(input logic [3:0] v, input logic [1:0] n);
    logic [7:0] dbl;
    dbl = {v, v} << n;
    return dbl[7:4];
  endfunction

endpackage

// File: rtl/des_hash_round.sv
// Combinational hash round: one S-box lookup of the input byte mixed into
// every state word with a neighbour shift and per-pair rotation.
module des_hash_round
  import des_hash_pkg::*;
#(
  parameter int NUM_H = 8
) (
  input  logic [4*NUM_H-1:0] h,
  input  logic [7:0]         x,
  output logic [4*NUM_H-1:0] h_next
);

  logic [3:0] s;

  assign s = sbox5(c6(x));

  always_comb begin
    h_next = '0;
    for (int i = 0; i < NUM_H; i++) begin
      h_next[4*i +: 4] = rotl4(h[4*((i+1)%NUM_H) +: 4] ^ s, 2'((i/2)%4));
    end
  end

endmodule

// File: rtl/des_sbox_hash_core.sv
// Byte-serial S-box hash core: absorbs msg_len bytes, then FINAL_ROUNDS
// rounds over the length bytes, then holds the digest.
//
//  state  | meaning
//  IDLE   | after reset, waiting for start
//  ABSORB | accepting message bytes, one round per transfer
//  FINAL  | one round per cycle over the low bytes of msg_len
//  DONE   | digest valid, waiting for the next start
module des_sbox_hash_core
  import des_hash_pkg::*;
#(
  parameter int                 NUM_H        = 8,
  parameter int                 LEN_W        = 64,
  parameter int                 FINAL_ROUNDS = 4,
  parameter logic [4*NUM_H-1:0] IV           = DEFAULT_IV
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LEN_W-1:0]   msg_len,
  input  logic               msg_valid,
  input  logic [7:0]         msg_byte,
  output logic               msg_ready,
  output logic               busy,
  output logic               hash_ready,
  output logic [4*NUM_H-1:0] digest
);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] ABSORB = ST_ABSORB;
  localparam logic [1:0] FINAL  = ST_FINAL;
  localparam logic [1:0] DONE   = ST_DONE;

  localparam int               RND_W    = $clog2(LEN_W/8 + 1);
  localparam logic [RND_W-1:0] LAST_RND = RND_W'((FINAL_ROUNDS > 0) ? FINAL_ROUNDS - 1 : 0);

  logic [1:0]         state;
  logic [4*NUM_H-1:0] h;
  logic [4*NUM_H-1:0] h_next;
  logic [LEN_W-1:0]   remaining;
  logic [LEN_W-1:0]   msg_len_q;
  logic [LEN_W-1:0]   len_shift;
  logic [RND_W-1:0]   round;
  logic [7:0]         round_x;

  assign msg_ready = (state == ABSORB);
  assign busy      = (state == ABSORB) || (state == FINAL);

  // Single round instance; FINAL feeds it the current length byte
  assign len_shift = msg_len_q >> {round, 3'b000};
  assign round_x   = (state == FINAL) ? len_shift[7:0] : msg_byte;

  des_hash_round #(.NUM_H(NUM_H)) u_round (
    .h      (h),
    .x      (round_x),
    .h_next (h_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      h          <= IV;
      remaining  <= '0;
      msg_len_q  <= '0;
      round      <= '0;
      hash_ready <= 1'b0;
      digest     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            h          <= IV;
            remaining  <= msg_len;
            msg_len_q  <= msg_len;
            round      <= '0;
            hash_ready <= 1'b0;
            if (msg_len != '0) begin
              state <= ABSORB;
            end else if (FINAL_ROUNDS > 0) begin
              state <= FINAL;
            end else begin
              state      <= DONE;
              digest     <= IV;
              hash_ready <= 1'b1;
            end
          end
        end
        ABSORB: begin
          if (msg_valid) begin
            h <= h_next;
            if (remaining != '0) begin
              remaining <= remaining - 1'b1;
            end
            if (remaining == LEN_W'(1)) begin
              if (FINAL_ROUNDS > 0) begin
                state <= FINAL;
              end else begin
                state      <= DONE;
                digest     <= h_next;
                hash_ready <= 1'b1;
              end
            end
          end
        end
        FINAL: begin
          h     <= h_next;
          round <= round + 1'b1;
          if (round == LAST_RND) begin
            state      <= DONE;
            digest     <= h_next;
            hash_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_sbox_hash_core.sv
// Self-checking bench for des_sbox_hash_core: one instance with default
// parameters and one with no length rounds, checked against a byte-level model.
module tb_des_sbox_hash_core;
  import des_hash_pkg::*;

  localparam logic [31:0] IV_REF = 32'h30FD17B4;

  typedef struct {
    logic [5:0] in;
    logic [3:0] exp;
  } sbox_vec_t;

  typedef struct {
    int          len;
    logic [7:0]  b;
    logic [31:0] dig;
    int          lat;
  } run_vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_s [2];
  logic [63:0] len_s   [2];
  logic        valid_s [2];
  logic [7:0]  byte_s  [2];
  logic        ready_s [2];
  logic        busy_s  [2];
  logic        hr_s    [2];
  logic [31:0] dig_s   [2];

  int checks = 0;
  int errors = 0;
  byte unsigned msg_q[$];
  int mh[8];

  // Standard DES S5, row-major
  int sb_tab [64] = '{
    2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
    14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
    4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
    11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3};

  always #5 clk = ~clk;

  des_sbox_hash_core #(.FINAL_ROUNDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .msg_len(len_s[0]),
    .msg_valid(valid_s[0]), .msg_byte(byte_s[0]), .msg_ready(ready_s[0]),
    .busy(busy_s[0]), .hash_ready(hr_s[0]), .digest(dig_s[0]));

  des_sbox_hash_core #(.FINAL_ROUNDS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .msg_len(len_s[1]),
    .msg_valid(valid_s[1]), .msg_byte(byte_s[1]), .msg_ready(ready_s[1]),
    .busy(busy_s[1]), .hash_ready(hr_s[1]), .digest(dig_s[1]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int bit_of(input int v, input int n);
    return (v >> n) & 1;
  endfunction

  function automatic int model_sbox(input int c);
    int row, col;
    row = 2 * bit_of(c, 5) + bit_of(c, 0);
    col = (c >> 1) & 15;
    return sb_tab[16*row + col];
  endfunction

  function automatic void model_round(input int x);
    int c, s, v, n;
    int hn[8];
    c = ((bit_of(x,3) ^ bit_of(x,2)) << 5) | (bit_of(x,1) << 4) | (bit_of(x,0) << 3) |
        (bit_of(x,7) << 2) | (bit_of(x,6) << 1) | (bit_of(x,5) ^ bit_of(x,4));
    s = model_sbox(c);
    for (int i = 0; i < 8; i++) begin
      v = mh[(i+1) % 8] ^ s;
      n = (i / 2) % 4;
      hn[i] = ((v << n) | (v >> (4 - n))) & 15;
    end
    for (int i = 0; i < 8; i++) mh[i] = hn[i];
  endfunction

  function automatic logic [31:0] model_hash(input int len, input int fr);
    logic [31:0] res;
    for (int i = 0; i < 8; i++) mh[i] = int'((IV_REF >> (4*i)) & 32'hF);
    for (int k = 0; k < len; k++) model_round(int'(msg_q[k]));
    for (int r = 0; r < fr; r++) model_round((len >> (8*r)) & 255);
    res = '0;
    for (int i = 0; i < 8; i++) res = res | (32'(mh[i]) << (4*i));
    return res;
  endfunction

  task automatic fill_random(input int len);
    msg_q = {};
    for (int k = 0; k < len; k++) msg_q.push_back(8'($urandom));
  endtask

  task automatic run_hash(input int d, input int len, input int gap, input bit rnd,
                          input bit noise, output int lat, output int busy_cnt,
                          output int active, output int stalls);
    int sent, wait_left, cyc;
    sent = 0; busy_cnt = 0; active = 0; stalls = 0; wait_left = gap;
    start_s[d] = 1'b1;
    len_s[d]   = 64'(len);
    valid_s[d] = noise;
    byte_s[d]  = 8'($urandom);
    step();
    start_s[d] = 1'b0;
    valid_s[d] = 1'b0;
    cyc = 1;
    while (!hr_s[d] && cyc < 4000) begin
      start_s[d] = 1'b0;
      valid_s[d] = 1'b0;
      if (ready_s[d]) begin
        if (wait_left > 0 || sent >= len) begin
          if (wait_left > 0) wait_left--;
          stalls++;
        end else begin
          valid_s[d] = 1'b1;
          byte_s[d]  = msg_q[sent];
          sent++;
          wait_left = gap + (rnd ? int'($urandom_range(0, 2)) : 0);
        end
        if (noise) begin
          start_s[d] = 1'b1;
          len_s[d]   = 64'($urandom_range(1, 9));
        end
      end else if (noise && busy_s[d]) begin
        start_s[d] = 1'b1;
        len_s[d]   = 64'($urandom_range(1, 9));
        valid_s[d] = 1'b1;
        byte_s[d]  = 8'($urandom);
      end
      if (busy_s[d]) busy_cnt++;
      if (busy_s[d] && !(ready_s[d] && !valid_s[d])) active++;
      step();
      cyc++;
    end
    start_s[d] = 1'b0;
    valid_s[d] = 1'b0;
    lat = cyc;
    chk("hash_ready reached", 64'(hr_s[d]), 64'd1);
  endtask

  task automatic hash_and_check(input string name, input int d, input int len,
                                input int gap, input bit rnd, input bit noise);
    int lat, bc, act, st, fr;
    fr = (d == 0) ? 4 : 0;
    run_hash(d, len, gap, rnd, noise, lat, bc, act, st);
    chk({name, " digest"}, 64'(dig_s[d]), 64'(model_hash(len, fr)));
    chk({name, " latency"}, 64'(lat), 64'(len + fr + 1 + st));
    chk({name, " busy cycles"}, 64'(bc), 64'(len + fr + st));
    chk({name, " active cycles"}, 64'(act), 64'(len + fr));
  endtask

  initial begin
    sbox_vec_t sv[4];
    run_vec_t  rv[2];
    int lat, bc, act, st, len, d;
    logic [31:0] exp_dig;

    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; len_s[i] = '0; valid_s[i] = 1'b0; byte_s[i] = '0;
    end

    sv[0] = '{6'h00, 4'h2};
    sv[1] = '{6'h01, 4'hE};
    sv[2] = '{6'h21, 4'hB};
    sv[3] = '{6'h3F, 4'h3};
    rv[0] = '{1, 8'h00, 32'h3887F659, 2};
    rv[1] = '{0, 8'h00, 32'h30FD17B4, 1};

    // S-box lookup, spot values then whole table
    foreach (sv[i]) chk("sbox vector", 64'(sbox5(sv[i].in)), 64'(sv[i].exp));
    for (int i = 0; i < 64; i++) chk("sbox table", 64'(sbox5(6'(i))), 64'(model_sbox(i)));

    step(); step();
    for (int i = 0; i < 2; i++) begin
      chk("reset digest", 64'(dig_s[i]), 64'd0);
      chk("reset hash_ready", 64'(hr_s[i]), 64'd0);
      chk("reset busy", 64'(busy_s[i]), 64'd0);
      chk("reset msg_ready", 64'(ready_s[i]), 64'd0);
    end
    rst_n = 1'b1;
    step();

    // No length rounds: fixed digests and latencies
    foreach (rv[i]) begin
      msg_q = {};
      msg_q.push_back(rv[i].b);
      run_hash(1, rv[i].len, 0, 1'b0, 1'b0, lat, bc, act, st);
      chk("fixed digest", 64'(dig_s[1]), 64'(rv[i].dig));
      chk("fixed latency", 64'(lat), 64'(rv[i].lat));
    end

    // Three bytes with a stall before each one
    fill_random(3);
    hash_and_check("gapped len3", 0, 3, 1, 1'b0, 1'b0);

    // start/bytes during ABSORB/FINAL ignored, then bytes offered in DONE
    fill_random(2);
    hash_and_check("noisy len2", 0, 2, 0, 1'b0, 1'b1);
    exp_dig = model_hash(2, 4);
    for (int k = 0; k < 3; k++) begin
      valid_s[0] = 1'b1;
      byte_s[0]  = 8'($urandom);
      step();
      chk("done msg_ready", 64'(ready_s[0]), 64'd0);
      chk("done busy", 64'(busy_s[0]), 64'd0);
      chk("done hash_ready", 64'(hr_s[0]), 64'd1);
      chk("done digest held", 64'(dig_s[0]), 64'(exp_dig));
    end
    valid_s[0] = 1'b0;

    // Reset in the middle of absorbing, then a clean run of the same data
    fill_random(5);
    start_s[0] = 1'b1; len_s[0] = 64'd5;
    step();
    start_s[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      valid_s[0] = 1'b1; byte_s[0] = msg_q[k];
      step();
    end
    valid_s[0] = 1'b0;
    rst_n = 1'b0;
    step();
    chk("abort digest", 64'(dig_s[0]), 64'd0);
    chk("abort hash_ready", 64'(hr_s[0]), 64'd0);
    chk("abort busy", 64'(busy_s[0]), 64'd0);
    chk("abort msg_ready", 64'(ready_s[0]), 64'd0);
    rst_n = 1'b1;
    step();
    hash_and_check("after abort", 0, 5, 0, 1'b0, 1'b0);

    // Randomised runs on both instances, including multi-byte lengths
    for (int it = 0; it < 16; it++) begin
      d   = it % 2;
      len = (it % 5 == 4) ? int'($urandom_range(256, 300)) : int'($urandom_range(0, 12));
      fill_random(len);
      hash_and_check("random", d, len, 0, 1'b1, bit'(it % 3 == 0));
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
